// File: rtl/sonar_note_mapper.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// sonar_note_mapper : distance -> note zone with hysteresis, DDS tuning word,
// octave shift and LED bar. Optional glide: define SONAR_GLIDE_EN. Rev 1.0
//==============================================================================
module sonar_note_mapper #(
  parameter int DIST_W       = 9,
  parameter int MIN_DIST     = 4,
  parameter int ZONE_SHIFT   = 3,
  parameter int NUM_NOTES    = 8,
  parameter int HOLD_SAMPLES = 3,
  parameter int LED_COUNT    = 16,
  parameter int GLIDE_STEP   = 256,
  parameter int GLIDE_DIV    = 1000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DIST_W-1:0]    distance,
  input  logic                 distance_valid,
  input  logic                 octave_up,
  input  logic                 octave_down,
  output logic [31:0]          tuning_word,
  output logic [4:0]           note_idx,
  output logic                 note_active,
  output logic                 note_change,
  output logic [LED_COUNT-1:0] led
);

  localparam logic [0:0] ST_MUTED  = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;
  localparam logic [3:0] HOLD      = 4'(HOLD_SAMPLES);

  // Stage 1: quantise the sample into a zone or out-of-range
  logic [DIST_W-1:0] offset_w;
  logic [DIST_W-1:0] zone_w;
  logic              oor_w;
  logic [4:0]        cand_q;
  logic              cand_oor_q;
  logic              cand_v_q;

  assign offset_w = distance - DIST_W'(MIN_DIST);
  assign zone_w   = offset_w >> ZONE_SHIFT;
  assign oor_w    = (distance < DIST_W'(MIN_DIST)) || (zone_w >= DIST_W'(NUM_NOTES));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand_q     <= 5'd0;
      cand_oor_q <= 1'b1;
      cand_v_q   <= 1'b0;
    end else begin
      cand_v_q <= distance_valid;
      if (distance_valid) begin
        cand_q     <= 5'(zone_w);
        cand_oor_q <= oor_w;
      end
    end
  end

  // Hysteresis FSM
  logic [0:0] state_q, state_d;
  logic [4:0] idx_q, idx_d;
  logic [4:0] pend_q, pend_d;
  logic       pend_oor_q, pend_oor_d;
  logic [3:0] cnt_q, cnt_d;
  logic       change_q, change_d;
  logic       match_cur_w;
  logic       match_pend_w;

  assign match_cur_w  = (state_q == ST_MUTED) ? cand_oor_q
                                              : (!cand_oor_q && (cand_q == idx_q));
  assign match_pend_w = cand_oor_q ? pend_oor_q : (!pend_oor_q && (cand_q == pend_q));

  always_comb begin
    logic [3:0] cnt_next;
    cnt_next   = cnt_q;
    state_d    = state_q;
    idx_d      = idx_q;
    pend_d     = pend_q;
    pend_oor_d = pend_oor_q;
    cnt_d      = cnt_q;
    change_d   = 1'b0;
    if (cand_v_q) begin
      if (match_cur_w) begin
        cnt_d = 4'd0;
      end else begin
        if (match_pend_w) begin
          cnt_next = (cnt_q >= HOLD) ? HOLD : cnt_q + 4'd1;
        end else begin
          pend_d     = cand_q;
          pend_oor_d = cand_oor_q;
          cnt_next   = 4'd1;
        end
        if (cnt_next >= HOLD) begin
          state_d  = pend_oor_d ? ST_MUTED : ST_LOCKED;
          if (!pend_oor_d) begin
            idx_d = pend_d;
          end
          change_d = 1'b1;
          cnt_d    = 4'd0;
        end else begin
          cnt_d = cnt_next;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_MUTED;
      idx_q      <= 5'd0;
      pend_q     <= 5'd0;
      pend_oor_q <= 1'b1;
      cnt_q      <= 4'd0;
      change_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      pend_q     <= pend_d;
      pend_oor_q <= pend_oor_d;
      cnt_q      <= cnt_d;
      change_q   <= change_d;
    end
  end

  // Degree table C4..B4, octave = index div 7
  function automatic logic [31:0] note_word(input logic [4:0] k);
    logic [4:0]  deg;
    logic [1:0]  oct;
    logic [31:0] base;
    if (k >= 5'd14) begin
      deg = k - 5'd14;
      oct = 2'd2;
    end else if (k >= 5'd7) begin
      deg = k - 5'd7;
      oct = 2'd1;
    end else begin
      deg = k;
      oct = 2'd0;
    end
    case (deg)
      5'd0:    base = 32'd11236;
      5'd1:    base = 32'd12612;
      5'd2:    base = 32'd14157;
      5'd3:    base = 32'd15000;
      5'd4:    base = 32'd16836;
      5'd5:    base = 32'd18899;
      default: base = 32'd21213;
    endcase
    return base << oct;
  endfunction

  logic [31:0] note_w;
  logic [31:0] target_w;

  assign note_w = note_word(idx_q);

  always_comb begin
    target_w = 32'd0;
    if (state_q == ST_LOCKED) begin
      if (octave_up && !octave_down) begin
        target_w = note_w << 1;
      end else if (octave_down && !octave_up) begin
        target_w = note_w >> 1;
      end else begin
        target_w = note_w;
      end
    end
  end

  logic [31:0] word_q, word_d;

`ifdef SONAR_GLIDE_EN
  localparam int DIV_W = (GLIDE_DIV > 1) ? $clog2(GLIDE_DIV) : 1;

  logic [DIV_W-1:0] div_q;
  logic             tick_w;
  logic [31:0]      diff_w;
  logic [31:0]      step_w;

  assign tick_w = (div_q == DIV_W'(GLIDE_DIV - 1));
  assign diff_w = (target_w > word_q) ? (target_w - word_q) : (word_q - target_w);
  assign step_w = (diff_w < 32'(GLIDE_STEP)) ? diff_w : 32'(GLIDE_STEP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
    end else begin
      div_q <= tick_w ? '0 : div_q + 1'b1;
    end
  end

  // Mute is immediate and a note out of silence jumps; otherwise glide
  always_comb begin
    word_d = word_q;
    if (target_w == 32'd0) begin
      word_d = 32'd0;
    end else if (word_q == 32'd0) begin
      word_d = target_w;
    end else if (tick_w) begin
      word_d = (target_w > word_q) ? (word_q + step_w) : (word_q - step_w);
    end
  end
`else
  logic unused_glide_w;
  assign unused_glide_w = ^{32'(GLIDE_STEP), 32'(GLIDE_DIV)};

  always_comb begin
    word_d = target_w;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q <= 32'd0;
    end else begin
      word_q <= word_d;
    end
  end

  generate
    for (genvar i = 0; i < LED_COUNT; i++) begin : g_led
      assign led[i] = (state_q == ST_LOCKED) && (32'(idx_q) >= 32'(i));
    end
  endgenerate

  assign tuning_word = word_q;
  assign note_idx    = idx_q;
  assign note_active = (state_q == ST_LOCKED);
  assign note_change = change_q;

endmodule
`default_nettype wire

// File: doc/sonar_note_mapper.md
# sonar_note_mapper

Parametrised distance-to-pitch mapper between the `sonar` driver and `tone_gen`. Quantises each valid distance sample into a note zone. A zone change takes effect only after it has persisted for a set number of samples (hysteresis). Outputs a 32-bit DDS tuning word with octave shift, optional glide, a note-change pulse and a thermometer LED bar.

## Interface
Parameters:
- `DIST_W`, 9: distance input width.
- `MIN_DIST`, 4: lowest in-range distance (inches).
- `ZONE_SHIFT`, 3: log2 of zone width; default zone width is 8.
- `NUM_NOTES`, 8: number of zones/notes, range 1..21.
- `HOLD_SAMPLES`, 3: consecutive matching samples required to change state, range 1..15.
- `LED_COUNT`, 16: LED bar width.
- `GLIDE_STEP`, 256: tuning-word increment per glide tick. Used only with the glide macro.
- `GLIDE_DIV`, 1000: clocks per glide tick. Used only with the glide macro.

Ports:
- `clk`  in  1  system clock, 100 MHz.
- `rst_n`  in  1  asynchronous, active-low reset.
- `distance`  in  DIST_W  distance sample from the sonar driver.
- `distance_valid`  in  1  one-cycle strobe; `distance` is sampled on this cycle.
- `octave_up`  in  1  shift output up one octave.
- `octave_down`  in  1  shift output down one octave.
- `tuning_word`  out  32  DDS tuning word to `tone_gen`; 0 means silence.
- `note_idx`  out  5  locked note index.
- `note_active`  out  1  a note is locked (not muted).
- `note_change`  out  1  one-cycle pulse when the locked state changes.
- `led`  out  LED_COUNT  thermometer bar of the locked note.

## Operation
- Degree table, C4..B4: 11236, 12612, 14157, 15000, 16836, 18899, 21213.
- Note word for index k: table[k mod 7] << (k div 7). Index 7 gives 22472 (C5).
- Stage 1 runs on each `distance_valid`:
  - distance < MIN_DIST → out of range (OOR).
  - Otherwise zone = (distance − MIN_DIST) >> ZONE_SHIFT.
  - zone ≥ NUM_NOTES → OOR.
  - Result is registered as `cand` (zone or OOR) together with a `cand_v` strobe.
- Hysteresis FSM, states MUTED and LOCKED, plus a candidate register `pend` and a counter `cnt`:
  - On `cand_v` with cand == current locked state (zone, or OOR while MUTED): `cnt` ← 0.
  - On `cand_v` with cand == pend: `cnt` increments, saturating at HOLD_SAMPLES.
  - On `cand_v` with any other cand: `pend` ← cand, `cnt` ← 1.
  - When `cnt` reaches HOLD_SAMPLES: the state adopts `pend`. A zone gives LOCKED with `note_idx` = zone; OOR gives MUTED. `note_change` pulses and `cnt` ← 0.
  - With HOLD_SAMPLES = 1, any differing sample switches on that sample.
- Target word:
  - MUTED gives 0.
  - LOCKED gives the note word, then:
    - `octave_up` alone: << 1.
    - `octave_down` alone: >> 1.
    - both or neither: unshifted.
  - The octave inputs are re-evaluated every clock and do not wait for a sample.
- LED bar: `led[i]` = `note_active` && i ≤ `note_idx`, for i < LED_COUNT. Indices ≥ LED_COUNT are not displayed.
- Reset values:
  - `tuning_word` 0, `note_idx` 0, `note_active` 0, `note_change` 0, `led` all 0.
  - FSM in MUTED, `cnt` 0, `pend` = OOR.
- Reset asserted mid-hold: the count is discarded and the FSM returns to MUTED.
- Samples arriving on consecutive cycles are all processed; there is no back-pressure.

## Timing
- `distance_valid` at cycle T → `cand_v` at T+1.
- The FSM update (`note_idx`, `note_active`, `note_change`, `led`) is visible at T+2.
- `tuning_word` is registered from the target and is visible at T+3 when glide is off.
- An octave input change reaches `tuning_word` one cycle later.
- `note_change` is high for exactly one cycle per transition.

## Configuration
- `SONAR_GLIDE_EN` defined:
  - Once per GLIDE_DIV clocks, `tuning_word` moves toward the target by min(GLIDE_STEP, |target − tuning_word|).
  - Exception: a target of 0 (mute) forces 0 immediately, and the first note after MUTED jumps directly to its target.
  - The glide-tick counter resets to 0.
- `SONAR_GLIDE_EN` undefined:
  - `tuning_word` equals the target one cycle later.
  - No glide counter is built, and GLIDE_STEP/GLIDE_DIV are ignored.

## Test plan
- Reset, then three valid samples of 30 → `note_idx` 3, `note_active` 1, `tuning_word` 15000, `led` = 0x000F, with a single `note_change` pulse.
- Locked at 30 (F4), then samples 45, 30, 45, 45, 45 → the note stays F4 until the third consecutive 45 locks note 5 (18899). The interleaved 30 resets the count.
- Locked at 60 (C5, 22472), then assert `octave_up` → 44944 one cycle later; assert both octave inputs → 22472; assert `octave_down` alone → 11236.
- Locked note, then three samples each of 2 and of 68 (both OOR) → `tuning_word` 0, `note_active` 0, `led` 0. Two OOR samples followed by one in-zone sample → no mute.
- Assert `rst_n` low after two of three matching samples → all outputs 0. After release, two more samples do not lock; three do.
- With `SONAR_GLIDE_EN`, GLIDE_DIV = 4, GLIDE_STEP = 256, moving C4 → D4 → the word climbs 11236, 11492, … and reaches 12612 exactly on the sixth tick without overshoot.
